// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and types for the 4-way stream demultiplexer
package stream_demux_pkg;
  localparam int N_OUT = 4;
  typedef logic [1:0] dest_t;
  typedef enum logic {IDLE, LOCKED} demux_state_t;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry valid/ready holding register (load wins over drain)
module stream_slot #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: packet-locked 1:4 valid/ready stream demux with per-lane slots and drop counting
import stream_demux_pkg::*;
module stream_demux4 #(
  parameter int           DATA_W    = 8,
  parameter logic [3:0]   DROP_MASK = 4'b0101,
  parameter int           CNT_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  input  logic                          in_last_i,
  input  dest_t                         in_dest_i,
  output logic [N_OUT-1:0]              out_valid_o,
  input  logic [N_OUT-1:0]              out_ready_i,
  output logic [N_OUT-1:0][DATA_W-1:0]  out_data_o,
  output logic [N_OUT-1:0]              out_last_o,
  output logic [CNT_W-1:0]              drop_cnt_o
);
  demux_state_t state, state_n;
  dest_t dest_q, eff;
  logic drop, acc;
  logic [N_OUT-1:0] load;
  logic [DATA_W:0] slot_q [N_OUT];
  assign eff = (state == LOCKED) ? dest_q : in_dest_i;
  assign drop = DROP_MASK[eff];
  assign in_ready_o = rst_ni && (drop || !out_valid_o[eff] || out_ready_i[eff]);
  assign acc = in_valid_i && in_ready_o;
  assign load = (acc && !drop) ? (4'b0001 << eff) : 4'b0000;
  always_comb state_n = acc ? (in_last_i ? IDLE : LOCKED) : state;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      dest_q     <= '0;
      drop_cnt_o <= '0;
    end else begin
      state <= state_n;
      if (acc && state == IDLE) dest_q <= in_dest_i;
      if (acc && drop && in_last_i && drop_cnt_o != {CNT_W{1'b1}}) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    stream_slot #(.W(DATA_W + 1)) u_slot (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load  (load[i]),
      .drain (out_valid_o[i] && out_ready_i[i]),
      .d     ({in_last_i, in_data_i}),
      .q     (slot_q[i]),
      .valid (out_valid_o[i])
    );
    assign out_last_o[i] = slot_q[i][DATA_W];
    assign out_data_o[i] = slot_q[i][DATA_W-1:0];
  end
endmodule
